alu_uart_if: RTL and testbench

Sequencer between the UART receive FIFO, the combinational ALU and the UART transmit FIFO. It pops three bytes from the RX FIFO (operand A, operand B, opcode), drives them as stable registered operands to the ALU, captures the result and pushes it into the TX FIFO. It is the only master of the RX FIFO read port and the TX FIFO write port, and it stalls on RX empty and TX full.

---
 rtl/alu_uart_if_pkg.sv | 15 +
 rtl/alu_uart_if.sv | 102 ++++++++++
 tb/tb_alu_uart_if.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_if_pkg.sv
// Shared definitions for the RX FIFO -> ALU -> TX FIFO sequencer.
// Opcode values live with the ALU; this package only carries sequencer state.
package alu_uart_if_pkg;

  localparam int unsigned NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_RD_A   = 3'd0,
    ST_RD_B   = 3'd1,
    ST_RD_OP  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WR_RES = 3'd4
  } state_e;

endpackage

// File: rtl/alu_uart_if.sv
// Pops operand A, operand B and opcode from the RX FIFO, presents them to the ALU as registered
// operands, captures the result and pushes it into the TX FIFO. Stalls on RX empty / TX full.
module alu_uart_if
  import alu_uart_if_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned NB_CNT  = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_empty,
  output logic               o_rx_rd,
  input  logic               i_tx_full,
  output logic               o_tx_wr,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic [NB_CNT-1:0]  o_op_cnt
);

  state_e state_q, state_d;

  logic [NB_DATA-1:0] a_q, b_q, res_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_CNT-1:0]  cnt_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RD_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o_rx_rd = 1'b0;
    o_tx_wr = 1'b0;
    case (state_q)
      ST_RD_A: begin
        if (!i_rx_empty) begin
          o_rx_rd = 1'b1;
          state_d = ST_RD_B;
        end
      end
      ST_RD_B: begin
        if (!i_rx_empty) begin
          o_rx_rd = 1'b1;
          state_d = ST_RD_OP;
        end
      end
      ST_RD_OP: begin
        if (!i_rx_empty) begin
          o_rx_rd = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WR_RES;
      ST_WR_RES: begin
        if (!i_tx_full) begin
          o_tx_wr = 1'b1;
          state_d = ST_RD_A;
        end
      end
      default: state_d = ST_RD_A;
    endcase
    // Strobes are Mealy; keep the FIFOs untouched while reset is held.
    if (i_rst) begin
      o_rx_rd = 1'b0;
      o_tx_wr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (o_rx_rd && (state_q == ST_RD_A))  a_q  <= i_rx_data;
      if (o_rx_rd && (state_q == ST_RD_B))  b_q  <= i_rx_data;
      if (o_rx_rd && (state_q == ST_RD_OP)) op_q <= i_rx_data[NB_OP-1:0];
      if (state_q == ST_EXEC)               res_q <= i_alu_result;
      if (o_tx_wr)                          cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_alu_a   = a_q;
  assign o_alu_b   = b_q;
  assign o_alu_op  = op_q;
  assign o_tx_data = res_q;
  assign o_op_cnt  = cnt_q;
  assign o_busy    = (state_q != ST_RD_A);

endmodule

// File: tb/tb_alu_uart_if.sv
// Randomized bench for alu_uart_if: FIFO/ALU environment plus a transaction-level result model.
module tb_alu_uart_if;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_empty;
  logic       o_rx_rd;
  logic       i_tx_full;
  logic       o_tx_wr;
  logic [7:0] o_tx_data;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_busy;
  logic [7:0] o_op_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // RX FIFO model: write side driven by stimulus, read side advanced by the DUT's pops
  logic [7:0] rx_mem [0:4095];
  int         rx_wp = 0;
  int         rx_rp = 0;
  int         pop_cyc [0:4095];
  // TX FIFO capture
  logic [7:0] tx_mem [0:1023];
  int         tx_cyc [0:1023];
  int         tx_cnt = 0;
  int         cyc = 0;
  int         exp_cnt = 0;
  logic       rnd_full = 1'b0;

  alu_uart_if #(.NB_DATA(8), .NB_OP(6), .NB_CNT(8)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_empty   (i_rx_empty),
    .o_rx_rd      (o_rx_rd),
    .i_tx_full    (i_tx_full),
    .o_tx_wr      (o_tx_wr),
    .o_tx_data    (o_tx_data),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy),
    .o_op_cnt     (o_op_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_fn(o_alu_a, o_alu_b, o_alu_op);
  assign i_rx_empty   = (rx_wp == rx_rp);
  assign i_rx_data    = rx_mem[rx_rp];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_rx_rd) begin
      pop_cyc[rx_rp] <= cyc;
      rx_rp          <= rx_rp + 1;
    end
    if (o_tx_wr) begin
      tx_mem[tx_cnt] <= o_tx_data;
      tx_cyc[tx_cnt] <= cyc;
      tx_cnt         <= tx_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) check("strobe_excl", {31'd0, o_rx_rd & o_tx_wr}, 32'd0);

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_wp] = b;
    rx_wp++;
  endtask

  task automatic wait_pushes(input int n, input int budget);
    int k = 0;
    while (tx_cnt < n && k < budget) begin
      @(negedge clk);
      if (rnd_full) i_tx_full = ($urandom_range(0, 2) == 0);
      k++;
    end
    i_tx_full = 1'b0;
    check("push_timeout", {31'd0, tx_cnt >= n}, 32'd1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (rx_rp < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("pop_timeout", {31'd0, rx_rp >= n}, 32'd1);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int gap, input logic chk_lat);
    int base;
    int nt;
    logic [7:0] exp;
    @(negedge clk);
    base = rx_wp;
    nt   = tx_cnt;
    exp  = alu_fn(a, b, opb[5:0]);
    push_byte(a);
    push_byte(b);
    if (gap > 0) begin
      wait_pops(base + 2, 20);
      repeat (gap) @(negedge clk);
      check("gap_rd", {31'd0, o_rx_rd}, 32'd0);
      check("gap_busy", {31'd0, o_busy}, 32'd1);
      check("gap_rp", rx_rp, base + 2);
    end
    push_byte(opb);
    wait_pushes(nt + 1, 300);
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    check("result", {24'd0, tx_mem[nt]}, {24'd0, exp});
    check("alu_a", {24'd0, o_alu_a}, {24'd0, a});
    check("alu_b", {24'd0, o_alu_b}, {24'd0, b});
    check("alu_op", {26'd0, o_alu_op}, {26'd0, opb[5:0]});
    check("op_cnt", {24'd0, o_op_cnt}, exp_cnt);
    if (chk_lat) begin
      check("pop_run", pop_cyc[base + 2] - pop_cyc[base], 32'd2);
      check("latency", tx_cyc[nt] - pop_cyc[base], 32'd4);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    logic [7:0] ops [0:5];
    logic [7:0] exp_arr [0:255];
    int base;
    int nt;
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24;
    ops[3] = 8'h25; ops[4] = 8'h26; ops[5] = 8'h27;
    i_rst     = 1'b1;
    i_tx_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a", {24'd0, o_alu_a}, 32'd0);
    check("rst_b", {24'd0, o_alu_b}, 32'd0);
    check("rst_op", {26'd0, o_alu_op}, 32'd0);
    check("rst_txd", {24'd0, o_tx_data}, 32'd0);
    check("rst_cnt", {24'd0, o_op_cnt}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_rd", {31'd0, o_rx_rd}, 32'd0);
    check("rst_wr", {31'd0, o_tx_wr}, 32'd0);
    i_rst = 1'b0;

    // Directed: 5 + 3 with full latency check
    run_txn(8'h05, 8'h03, 8'h20, 0, 1'b1);
    check("add_res", {24'd0, tx_mem[0]}, 32'h08);

    // Opcode byte delayed 40 cycles: 0x10 - 0x20
    run_txn(8'h10, 8'h20, 8'h22, 40, 1'b0);
    check("sub_res", {24'd0, tx_mem[1]}, 32'hF0);

    // Upper opcode bits dropped
    run_txn(8'h5A, 8'h3C, 8'hE4, 0, 1'b1);
    check("op_trunc", {26'd0, o_alu_op}, 32'h24);

    // TX full held 10 cycles in the write state
    @(negedge clk);
    i_tx_full = 1'b1;
    base = rx_wp;
    nt   = tx_cnt;
    push_byte(8'h77);
    push_byte(8'h11);
    push_byte(8'h26);
    wait_pops(base + 3, 20);
    repeat (2) @(negedge clk);
    push_byte(8'h09);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_wr", {31'd0, o_tx_wr}, 32'd0);
      check("full_txd", {24'd0, o_tx_data}, 32'h66);
    end
    check("full_nopop", rx_rp, base + 3);
    check("full_nopush", tx_cnt, nt);
    i_tx_full = 1'b0;
    wait_pushes(nt + 1, 10);
    repeat (4) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    check("full_one_push", tx_cnt, nt + 1);
    check("full_res", {24'd0, tx_mem[nt]}, 32'h66);
    check("full_cnt", {24'd0, o_op_cnt}, exp_cnt);
    push_byte(8'h04);
    push_byte(8'h25);
    wait_pushes(nt + 2, 20);
    exp_cnt = (exp_cnt + 1) % 256;
    @(negedge clk);
    check("after_full_res", {24'd0, tx_mem[nt + 1]}, 32'h0D);

    // Async reset while collecting operand B
    base = rx_wp;
    push_byte(8'hAA);
    wait_pops(base + 1, 10);
    check("rdb_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk);
    #2 i_rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, o_busy}, 32'd0);
    check("arst_a", {24'd0, o_alu_a}, 32'd0);
    check("arst_cnt", {24'd0, o_op_cnt}, 32'd0);
    check("arst_txd", {24'd0, o_tx_data}, 32'd0);
    check("arst_rd", {31'd0, o_rx_rd}, 32'd0);
    @(negedge clk);
    i_rst = 1'b0;
    exp_cnt = 0;
    run_txn(8'h21, 8'h12, 8'h22, 0, 1'b1);

    // Randomized transactions with random gaps and TX back-pressure
    for (int t = 0; t < 20; t++) begin
      rnd_full = $urandom_range(0, 1);
      run_txn($urandom_range(0, 255), $urandom_range(0, 255), ops[$urandom_range(0, 5)],
              $urandom_range(0, 3), 1'b0);
    end
    rnd_full = 1'b0;

    // 256 back-to-back ADDs: 5-cycle spacing, counter wraps to 0
    do_reset();
    @(negedge clk);
    nt = tx_cnt;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      exp_arr[k] = a + b;
      push_byte(a);
      push_byte(b);
      push_byte(8'h20);
    end
    wait_pushes(nt + 256, 2000);
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      check("b2b_res", {24'd0, tx_mem[nt + k]}, {24'd0, exp_arr[k]});
      if (k > 0) check("b2b_gap", tx_cyc[nt + k] - tx_cyc[nt + k - 1], 32'd5);
    end
    check("b2b_wrap", {24'd0, o_op_cnt}, 32'd0);
    check("b2b_idle", {31'd0, o_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
